// File: rtl/line_scaler_pkg.sv
// Shared constants and helpers for the line_scaler horizontal pixel replicator.
package line_scaler_pkg;

    localparam int PIX_W_DEF = 24;
    localparam int CH_W      = 8;
    localparam int REP_W     = 4;

    localparam logic [PIX_W_DEF-1:0] BORDER_DEF = '0;
    localparam logic [REP_W-1:0]     REP_MAX    = '1;

    // Index width that stays legal when the count is 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_scaler_dpram.sv
// Simple dual-port line RAM (one write port, one registered read port) for block RAM inference.
module line_scaler_dpram #(
    parameter int DW = 24,
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Depth is a power of two so the {bank,index} address never leaves the array.
    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_scaler.sv
// Double-buffered line scaler: captures one source line and replays it H_SCALE times wider.
// Optional scanline dimming of odd repeats is enabled by defining LINE_SCALER_SCANLINE_EN.
module line_scaler
    import line_scaler_pkg::*;
#(
    parameter int               PIX_W     = PIX_W_DEF,
    parameter int               IN_PIXELS = 256,
    parameter int               H_SCALE   = 2,
    parameter logic [PIX_W-1:0] BORDER    = PIX_W'(BORDER_DEF)
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sol,
    input  logic             out_sol,
    input  logic             out_en,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             line_ready,
    output logic [REP_W-1:0] rep_cnt,
    output logic             overrun
);

    localparam int IDX_W = idx_width(IN_PIXELS);
    localparam int RDX_W = $clog2(IN_PIXELS + 1);
    localparam int PH_W  = idx_width(H_SCALE);
    localparam int AW    = IDX_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_PIXELS - 1);
    localparam logic [RDX_W-1:0] RD_END   = RDX_W'(IN_PIXELS);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(H_SCALE - 1);

    logic             r_wr_bank;
    logic [IDX_W-1:0] r_wr_x;
    logic             r_line_ready;
    logic             r_overrun;
    logic             r_have_line;
    logic [REP_W-1:0] r_rep_cnt;
    logic [RDX_W-1:0] r_rd_x;
    logic [PH_W-1:0]  r_ph;
    logic             r_en_d1;
    logic             r_border_d1;
    logic [PIX_W-1:0] r_out_data;
    logic             r_out_valid;

    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_wr_last;
    logic             w_swap;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_border;
    logic [PIX_W-1:0] w_rd_data;
    logic [PIX_W-1:0] w_pix_d1;

    // ---------------- write side ----------------
    assign w_wr_en   = in_valid & ~r_line_ready;
    assign w_wr_idx  = in_sol ? '0 : r_wr_x;
    assign w_wr_last = w_wr_en & (w_wr_idx == LAST_IDX);
    // A line finishing in the same cycle as out_sol is swapped in immediately.
    assign w_swap    = out_sol & (r_line_ready | w_wr_last);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_wr_bank    <= 1'b0;
            r_wr_x       <= '0;
            r_line_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_have_line  <= 1'b0;
            r_rep_cnt    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_x <= w_wr_last ? '0 : w_wr_idx + IDX_W'(1);
            end else if (in_sol) begin
                r_wr_x <= '0;
            end

            if (in_valid && r_line_ready) begin
                r_overrun <= 1'b1;
            end

            if (w_swap) begin
                r_wr_bank    <= ~r_wr_bank;
                r_line_ready <= 1'b0;
                r_have_line  <= 1'b1;
                r_rep_cnt    <= '0;
            end else begin
                if (w_wr_last) begin
                    r_line_ready <= 1'b1;
                end
                if (out_sol && r_rep_cnt != REP_MAX) begin
                    r_rep_cnt <= r_rep_cnt + REP_W'(1);
                end
            end
        end
    end

    // ---------------- read side ----------------
    assign w_rd_border = ~r_have_line | (r_rd_x == RD_END);
    assign w_rd_idx    = (r_rd_x == RD_END) ? '0 : r_rd_x[IDX_W-1:0];

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_rd_x <= '0;
            r_ph   <= '0;
        end else if (out_sol) begin
            r_rd_x <= '0;
            r_ph   <= '0;
        end else if (out_en) begin
            if (r_ph == PH_LAST) begin
                r_ph <= '0;
                if (r_rd_x != RD_END) begin
                    r_rd_x <= r_rd_x + RDX_W'(1);
                end
            end else begin
                r_ph <= r_ph + PH_W'(1);
            end
        end
    end

    // Writes always hit r_wr_bank and reads the opposite bank, so the ports never collide.
    line_scaler_dpram #(
        .DW (PIX_W),
        .AW (AW)
    ) u_ram (
        .i_clk   (pclk),
        .i_we    (w_wr_en),
        .i_waddr ({r_wr_bank, w_wr_idx}),
        .i_wdata (in_data),
        .i_re    (out_en),
        .i_raddr ({~r_wr_bank, w_rd_idx}),
        .o_rdata (w_rd_data)
    );

`ifdef LINE_SCALER_SCANLINE_EN
    logic             r_dim_d1;
    logic [PIX_W-1:0] w_dimmed;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_dim_d1 <= 1'b0;
        end else begin
            r_dim_d1 <= r_rep_cnt[0];
        end
    end

    for (genvar gi = 0; gi < PIX_W / CH_W; gi++) begin : g_dim
        assign w_dimmed[gi*CH_W +: CH_W] = {1'b0, w_rd_data[gi*CH_W+1 +: CH_W-1]};
    end

    assign w_pix_d1 = r_border_d1 ? BORDER : (r_dim_d1 ? w_dimmed : w_rd_data);
`else
    assign w_pix_d1 = r_border_d1 ? BORDER : w_rd_data;
`endif

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_en_d1     <= 1'b0;
            r_border_d1 <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_en_d1     <= out_en;
            r_border_d1 <= w_rd_border;
            r_out_valid <= r_en_d1;
            r_out_data  <= r_en_d1 ? w_pix_d1 : '0;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign line_ready = r_line_ready;
    assign rep_cnt    = r_rep_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_line_scaler.sv
// Directed self-checking bench for line_scaler (IN_PIXELS=4, H_SCALE=2, non-zero BORDER).
module tb_line_scaler;

    localparam logic [23:0] BRD = 24'h123456;
    localparam logic [23:0] PA = 24'h808080, PB = 24'h112233, PC = 24'h445566, PD = 24'h778899;
    localparam logic [23:0] PE = 24'h0A0B0C, PF = 24'h1A1B1C, PG = 24'h2A2B2C, PH = 24'h3A3B3C;
    localparam logic [23:0] PI = 24'h010203, PJ = 24'h040506, PK = 24'h070809, PL = 24'h0A0A0A;
    localparam logic [23:0] PM = 24'hA1A2A3, PN = 24'hB1B2B3, PO = 24'hC1C2C3, PP = 24'hD1D2D3;
    localparam logic [23:0] PX = 24'hDEAD01, PS = 24'h313233, PT = 24'h414243, PU = 24'h515253;
    localparam logic [23:0] PV = 24'h616263;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_sol = 1'b0;
    logic        out_sol = 1'b0;
    logic        out_en = 1'b0;
    logic [23:0] out_data;
    logic        out_valid;
    logic        line_ready;
    logic [3:0]  rep_cnt;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];
    logic [23:0] a_rep1;

    always #5 pclk = ~pclk;

    line_scaler #(
        .PIX_W     (24),
        .IN_PIXELS (4),
        .H_SCALE   (2),
        .BORDER    (BRD)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sol     (in_sol),
        .out_sol    (out_sol),
        .out_en     (out_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .line_ready (line_ready),
        .rep_cnt    (rep_cnt),
        .overrun    (overrun)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_data"}, 32'(out_data), 32'h0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'h0);
        check({tag, ".line_ready"}, 32'(line_ready), 32'h0);
        check({tag, ".rep_cnt"}, 32'(rep_cnt), 32'h0);
        check({tag, ".overrun"}, 32'(overrun), 32'h0);
    endtask

    task automatic write_px(input logic [23:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic sol();
        out_sol = 1'b1;
        tick();
        out_sol = 1'b0;
    endtask

    // Drives out_en for exp_q.size() cycles; output k lags the sample by two edges.
    task automatic show(input string tag);
        int n;
        n = exp_q.size();
        out_en = 1'b1;
        for (int k = 1; k <= n + 2; k++) begin
            tick();
            if (k == n) out_en = 1'b0;
            if (k >= 2 && k <= n + 1) begin
                check($sformatf("%s.valid[%0d]", tag, k - 2), 32'(out_valid), 32'h1);
                check($sformatf("%s.data[%0d]", tag, k - 2), 32'(out_data), 32'(exp_q[k-2]));
            end else if (k == n + 2) begin
                check($sformatf("%s.idle_valid", tag), 32'(out_valid), 32'h0);
                check($sformatf("%s.idle_data", tag), 32'(out_data), 32'h0);
            end
        end
        $display("line %s: %0d pixels compared", tag, n);
    endtask

    initial begin
`ifdef LINE_SCALER_SCANLINE_EN
        a_rep1 = 24'h404040;
`else
        a_rep1 = PA;
`endif
        tick(); tick(); tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // No line ever written: border only.
        sol();
        check("noline.rep_cnt", 32'(rep_cnt), 32'h1);
        exp_q = {BRD, BRD, BRD};
        show("noline");

        // Basic 2x replication with border after the line end.
        write_px(PA); write_px(PB); write_px(PC); write_px(PD);
        check("fill1.line_ready", 32'(line_ready), 32'h1);
        sol();
        check("swap1.line_ready", 32'(line_ready), 32'h0);
        check("swap1.rep_cnt", 32'(rep_cnt), 32'h0);
        exp_q = {PA, PA, PB, PB, PC, PC, PD, PD, BRD, BRD};
        show("scale");

        // Repeats of the same line.
        sol();
        check("rep1.rep_cnt", 32'(rep_cnt), 32'h1);
        exp_q = {a_rep1, a_rep1};
        show("rep1");
        sol();
        check("rep2.rep_cnt", 32'(rep_cnt), 32'h2);
        exp_q = {PA, PA, PB, PB};
        show("rep2");

        // Line completion coinciding with out_sol.
        write_px(PE); write_px(PF); write_px(PG);
        in_valid = 1'b1; in_data = PH; out_sol = 1'b1;
        tick();
        in_valid = 1'b0; out_sol = 1'b0;
        check("coinc.line_ready", 32'(line_ready), 32'h0);
        check("coinc.rep_cnt", 32'(rep_cnt), 32'h0);
        exp_q = {PE, PE, PF, PF, PG, PG, PH, PH};
        show("coinc");

        // Overrun: extra pixel after a complete line is dropped.
        write_px(PI); write_px(PJ); write_px(PK); write_px(PL);
        check("ovr.pre_overrun", 32'(overrun), 32'h0);
        write_px(PX);
        check("ovr.overrun", 32'(overrun), 32'h1);
        check("ovr.line_ready", 32'(line_ready), 32'h1);
        sol();
        exp_q = {PI, PI, PJ, PJ, PK, PK, PL, PL};
        show("ovr_line");
        write_px(PM); write_px(PN); write_px(PO); write_px(PP);
        sol();
        exp_q = {PM, PM, PN, PN, PO, PO, PP, PP};
        show("after_ovr");
        check("ovr.sticky", 32'(overrun), 32'h1);

        // Reset mid-line discards the partial line and hides stale RAM.
        write_px(PS); write_px(PT);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        tick();
        check_zero("held_rst");
        rst = 1'b0;
        tick();
        sol();
        check("postrst.rep_cnt", 32'(rep_cnt), 32'h1);
        exp_q = {BRD, BRD, BRD};
        show("postrst");
        write_px(PS); write_px(PT); write_px(PU); write_px(PV);
        check("postrst.line_ready", 32'(line_ready), 32'h1);
        exp_q = {BRD, BRD};
        show("postrst_noswap");
        sol();
        exp_q = {PS, PS, PT, PT, PU, PU, PV, PV};
        show("postrst_line");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_scaler.md
LINE_SCALER -- requirements
Module: line_scaler

Interface
REQ-001 SHALL have parameter PIX_W, default 24, pixel width as {blue,green,red} with 8 bits per channel.
REQ-002 SHALL have parameter IN_PIXELS, default 256, the number of source pixels per line.
REQ-003 SHALL have parameter H_SCALE, default 2, the horizontal replication factor (legal range 1..8).
REQ-004 SHALL have parameter BORDER, default 0, the colour emitted outside the scaled line.
REQ-005 SHALL have ports: pclk in 1 pixel clock; rst in 1 reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports: in_valid in 1 source pixel strobe; in_data in PIX_W source pixel; in_sol in 1 source start-of-line pulse.
REQ-007 SHALL have ports: out_sol in 1 display start-of-line pulse; out_en in 1 display active-pixel enable.
REQ-008 SHALL have ports: out_data out PIX_W pixel; out_valid out 1; line_ready out 1 pending complete line; rep_cnt out 4 display repeats of the current line; overrun out 1 sticky error.

Function
REQ-009 SHALL hold two line banks of IN_PIXELS entries each: one write bank (wr_bank) and one read bank (~wr_bank).
REQ-010 Each in_valid while line_ready=0 SHALL write in_data to wr_bank[wr_x], then increment wr_x.
REQ-011 in_sol SHALL clear wr_x to 0 and abandon any partial line; if in_sol and in_valid coincide, the pixel SHALL be written at index 0.
REQ-012 Writing index IN_PIXELS-1 SHALL set line_ready=1 and clear wr_x to 0.
REQ-013 An in_valid while line_ready=1 SHALL be dropped and SHALL set overrun=1, which stays set until reset.
REQ-014 out_sol with line_ready=1 (including line_ready being set in the same cycle) SHALL toggle wr_bank, clear line_ready, set have_line=1 and clear rep_cnt to 0.
REQ-015 out_sol with line_ready=0 SHALL keep the banks, so the read bank is re-displayed, and SHALL increment rep_cnt, saturating at 15.
REQ-016 out_sol SHALL clear the source read index rd_x and the phase counter ph to 0.
REQ-017 Each cycle with out_en=1, ph SHALL increment; at ph=H_SCALE-1, ph SHALL wrap to 0 and rd_x SHALL increment, saturating at IN_PIXELS.
REQ-018 The pixel sampled in a cycle with out_en=1 SHALL appear on out_data exactly 2 cycles later (RAM read plus output register), with out_valid=1 in that same cycle.
REQ-019 The sampled pixel SHALL be the read bank at rd_x, or BORDER if rd_x=IN_PIXELS or have_line=0.
REQ-020 If out_en=0 two cycles earlier, out_data SHALL be 0 and out_valid SHALL be 0.
REQ-021 A write and a read SHALL never target the same bank in the same cycle; the RAM SHALL need no read-during-write resolution.

Reset
REQ-022 While rst=1, all outputs SHALL be 0 (out_data, out_valid, line_ready, rep_cnt, overrun), and wr_x, rd_x, ph, wr_bank and have_line SHALL be 0.
REQ-023 RAM contents SHALL NOT be reset; BORDER masking via have_line SHALL hide them.
REQ-024 Reset asserted mid-line SHALL discard the partial line; the first output after release SHALL be BORDER until a full line has been swapped in.

Configuration
REQ-025 With LINE_SCALER_SCANLINE_EN defined, output pixels on lines with odd rep_cnt SHALL have each 8-bit channel shifted right by 1, and BORDER SHALL NOT be dimmed.
REQ-026 Without LINE_SCALER_SCANLINE_EN, all repeats SHALL be identical, with no added logic or latency.

Structure
REQ-027 Package line_scaler_pkg SHALL hold PIX_W default, channel width 8, BORDER default and the rep_cnt width.
REQ-028 Sub-module line_scaler_dpram SHALL provide a simple dual-port RAM of 2*IN_PIXELS x PIX_W, mapped to block RAM, with a registered read; addresses SHALL be {bank,index}.

Verification
REQ-029 With IN_PIXELS=4, H_SCALE=2: write A,B,C,D; out_sol; out_en for 10 cycles -> out_data A,A,B,B,C,C,D,D,BORDER,BORDER starting 2 cycles after out_en rises.
REQ-030 With no line written: out_sol then out_en for 3 cycles -> out_data = BORDER x3, out_valid=1.
REQ-031 Write one line, then 3 out_sol with no new line -> rep_cnt = 0,1,2 and the same pixels each line; with LINE_SCALER_SCANLINE_EN, pixel 0x808080 shows as 0x404040 on rep_cnt 1.
REQ-032 Complete a line, then send 1 more in_valid before out_sol -> overrun=1 and the extra pixel is absent from the next-but-one line.
REQ-033 Line completion and out_sol in the same cycle -> swap occurs, line_ready=0 next cycle, rep_cnt=0.
REQ-034 Assert rst after 2 of 4 pixels are written -> all outputs 0; after release, BORDER is shown until a full line has been written and out_sol received.
